// File: rtl/apb3_timer_pkg.sv
// Shared definitions for the APB3 timer slave: register offsets, CTRL layout, bus phase enum.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: OFF_* byte offsets, CTRL_* bit positions, bus_state_t, ctrl_reg_t, CTRL pack/unpack helpers.
package apb3_timer_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_LOAD   = 8'h04;
  localparam logic [7:0] OFF_VALUE  = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_ID     = 8'h10;
  localparam logic [7:0] OFF_END    = 8'h14;  // first offset that is not a register

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_AR_BIT = 1;
  localparam int CTRL_IE_BIT = 2;
  localparam int CTRL_PS_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } bus_state_t;

  typedef struct packed {
    logic [7:0] prescale;
    logic       irq_en;
    logic       auto_reload;
    logic       en;
  } ctrl_reg_t;

  function automatic logic [31:0] ctrl_to_word(ctrl_reg_t c);
    return {16'h0000, c.prescale, 5'b00000, c.irq_en, c.auto_reload, c.en};
  endfunction

  function automatic ctrl_reg_t word_to_ctrl(logic [31:0] w);
    ctrl_reg_t c;
    c.prescale    = w[CTRL_PS_LSB +: 8];
    c.irq_en      = w[CTRL_IE_BIT];
    c.auto_reload = w[CTRL_AR_BIT];
    c.en          = w[CTRL_EN_BIT];
    return c;
  endfunction

endpackage

// File: rtl/apb3_timer_slave_if.sv
// APB3 completer-side bus bundle (PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PRDATA/PREADY/PSLVERR out).
// Latency: n/a (wires only).
// Backpressure: the completer stretches the access phase by holding pready low.
// Modports: master drives the request fields, slave drives the response fields.
interface apb3_timer_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb3_timer_core.sv
// Prescaled down-counter with auto-reload and sticky EXPIRED flag.
// Latency: VALUE/EXPIRED update on the clock edge of a tick or register write strobe.
// Backpressure: none; strobes are single-cycle and always accepted.
// Ports: clk/rst; ctrl + load_val (current regs); load_wr/en_rise/status_w1c strobes with wr_data;
//        value, expired, hw_en_clr (one-shot expiry asks the top to drop EN).
module apb3_timer_core
  import apb3_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ctrl_reg_t   ctrl,
  input  logic [31:0] load_val,
  input  logic        load_wr,
  input  logic        en_rise,
  input  logic        status_w1c,
  input  logic [31:0] wr_data,
  output logic [31:0] value,
  output logic        expired,
  output logic        hw_en_clr
);

  logic [7:0] presc_q;
  logic       tick;
  logic       fire;

  assign tick      = ctrl.en && (presc_q == ctrl.prescale);
  // Zero is checked before decrementing, so VALUE never wraps below 0.
  assign fire      = tick && (value == 32'd0);
  assign hw_en_clr = fire && !ctrl.auto_reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 8'd0;
      value   <= 32'd0;
      expired <= 1'b0;
    end else begin
      if (en_rise || tick) begin
        presc_q <= 8'd0;
      end else if (ctrl.en) begin
        presc_q <= presc_q + 8'd1;
      end

      // A tick implies EN=1, and LOAD only lands in VALUE while EN=0.
      if (tick) begin
        if (value != 32'd0) begin
          value <= value - 32'd1;
        end else if (ctrl.auto_reload) begin
          value <= load_val;
        end
      end else if (load_wr && !ctrl.en) begin
        value <= wr_data;
      end

      // Hardware set beats a same-cycle software clear.
      if (fire) begin
        expired <= 1'b1;
      end else if (status_w1c) begin
        expired <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb3_timer_slave.sv
// APB3 completer with a prescaled timer: CTRL/LOAD/VALUE/STATUS/ID registers plus level interrupt.
// Latency: SETUP + (WAIT_STATES+1) ACCESS cycles per transfer; o_irq lags EXPIRED&IRQ_EN by one cycle.
// Backpressure: pready held low for WAIT_STATES access cycles; psel dropping mid-access aborts cleanly.
// Ports: i_clk, i_rst (sync, active-high), apb (slave modport), o_irq.
module apb3_timer_slave
  import apb3_timer_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH = 32,
  parameter int          APB_DATA_WIDTH = 32,
  parameter int          WAIT_STATES    = 0,
  parameter logic [31:0] ID_VALUE       = 32'h5449_4D31
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  apb3_timer_slave_if.slave    apb,
  output logic                 o_irq
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  bus_state_t                state_q;
  bus_state_t                phase;
  logic [2:0]                wait_cnt;
  ctrl_reg_t                 ctrl_q;
  logic [APB_DATA_WIDTH-1:0] load_q;
  logic [APB_DATA_WIDTH-1:0] rd_word;
  logic [7:0]                offset;
  logic                      ready;
  logic                      complete;
  logic                      err;
  logic                      wr_ok;
  logic                      wr_ctrl;
  logic                      wr_load;
  logic                      wr_status;
  logic                      en_rise;
  logic [31:0]               value;
  logic                      expired;
  logic                      hw_en_clr;
  logic                      unused_addr;

  // The register window is 256 bytes: bits [7:5] must be zero for a hit,
  // anything above bit 7 is the bridge's slot select and is ignored.
  assign offset      = {apb.paddr[7:2], 2'b00};
  assign unused_addr = ^{apb.paddr[APB_ADDR_WIDTH-1:8], apb.paddr[1:0]};

  // The setup cycle is recognised combinationally so that ACCESS is already
  // registered in the very next cycle (two-cycle transfer with no waits).
  always_comb begin
    phase = IDLE;
    if (state_q == ACCESS) begin
      phase = ACCESS;
    end else if (apb.psel && !apb.penable) begin
      phase = SETUP;
    end
  end

  assign ready    = (state_q == ACCESS) && (wait_cnt == WS) && !i_rst;
  assign complete = apb.psel && apb.penable && ready;
  assign err      = (offset >= OFF_END) ||
                    (apb.pwrite && ((offset == OFF_VALUE) || (offset == OFF_ID)));

  assign wr_ok     = complete && apb.pwrite && !err;
  assign wr_ctrl   = wr_ok && (offset == OFF_CTRL);
  assign wr_load   = wr_ok && (offset == OFF_LOAD);
  assign wr_status = wr_ok && (offset == OFF_STATUS) && apb.pwdata[0];
  assign en_rise   = wr_ctrl && apb.pwdata[CTRL_EN_BIT] && !ctrl_q.en;

  always_comb begin
    rd_word = '0;
    case (offset)
      OFF_CTRL:   rd_word = ctrl_to_word(ctrl_q);
      OFF_LOAD:   rd_word = load_q;
      OFF_VALUE:  rd_word = value;
      OFF_STATUS: rd_word = {31'd0, expired};
      OFF_ID:     rd_word = ID_VALUE;
      default:    rd_word = '0;
    endcase
  end

  assign apb.pready  = ready;
  assign apb.pslverr = ready && err;
  assign apb.prdata  = (ready && !apb.pwrite && !err) ? rd_word : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wait_cnt <= 3'd0;
      ctrl_q   <= '0;
      load_q   <= '0;
      o_irq    <= 1'b0;
    end else begin
      case (phase)
        SETUP: begin
          state_q  <= ACCESS;
          wait_cnt <= 3'd0;
        end
        ACCESS: begin
          if (!apb.psel || complete) begin
            state_q  <= IDLE;
            wait_cnt <= 3'd0;
          end else if (wait_cnt < WS) begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          wait_cnt <= 3'd0;
        end
      endcase

      // A software CTRL write overrides the one-shot hardware EN clear.
      if (wr_ctrl) begin
        ctrl_q <= word_to_ctrl(apb.pwdata);
      end else if (hw_en_clr) begin
        ctrl_q.en <= 1'b0;
      end

      if (wr_load) begin
        load_q <= apb.pwdata;
      end

      o_irq <= expired && ctrl_q.irq_en;
    end
  end

  apb3_timer_core u_core (
    .clk        (i_clk),
    .rst        (i_rst),
    .ctrl       (ctrl_q),
    .load_val   (load_q),
    .load_wr    (wr_load),
    .en_rise    (en_rise),
    .status_w1c (wr_status),
    .wr_data    (apb.pwdata),
    .value      (value),
    .expired    (expired),
    .hw_en_clr  (hw_en_clr)
  );

endmodule

// File: tb/tb_apb3_timer_slave.sv
module tb_apb3_timer_slave;
  import apb3_timer_pkg::*;

  localparam int          WS = 3;
  localparam logic [31:0] ID = 32'h5449_4D31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb3_timer_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0(), bus();
  logic irq0, irq;

  apb3_timer_slave #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
    .i_clk(clk), .i_rst(rst), .apb(bus0.slave), .o_irq(irq0));
  apb3_timer_slave #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .WAIT_STATES(WS), .ID_VALUE(ID)) dut (
    .i_clk(clk), .i_rst(rst), .apb(bus.slave), .o_irq(irq));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_en = 0, m_ar = 0, m_ie = 0, m_exp = 0, m_irq = 0;
  logic [7:0]  m_ps = 0, m_presc = 0;
  logic [31:0] m_load = 0, m_value = 0;

  // Driver-owned flags describing the cycle currently on the bus.
  bit          exp_pready = 0, comp_now = 0, comp_wr = 0;
  logic [31:0] comp_addr = 0, comp_data = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;
  exp_t sb[$];

  function automatic bit is_err(bit wr, logic [31:0] a);
    logic [7:0] off;
    off = a[7:0] & 8'hFC;
    return (off >= 8'h14) || (wr && (off == 8'h08 || off == 8'h10));
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    logic [7:0] off;
    off = a[7:0] & 8'hFC;
    case (off)
      8'h00:   return {16'h0, m_ps, 5'h0, m_ie, m_ar, m_en};
      8'h04:   return m_load;
      8'h08:   return m_value;
      8'h0C:   return {31'h0, m_exp};
      8'h10:   return ID;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit         en0, tick, fire, wr_ok;
    logic [7:0] off;
    if (rst) begin
      m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_irq = 0;
      m_ps = 0; m_presc = 0; m_load = 0; m_value = 0;
    end else begin
      en0   = m_en;
      tick  = m_en && (m_presc == m_ps);
      fire  = tick && (m_value == 0);
      m_irq = m_exp && m_ie;
      wr_ok = comp_now && comp_wr && !is_err(1'b1, comp_addr);
      off   = comp_addr[7:0] & 8'hFC;
      if (m_en) m_presc = tick ? 8'd0 : m_presc + 8'd1;
      if (tick) begin
        if (m_value != 0) m_value = m_value - 1;
        else begin
          m_exp = 1;
          if (m_ar) m_value = m_load;
          else m_en = 0;
        end
      end
      if (wr_ok) begin
        case (off)
          8'h00: begin
            if (comp_data[0] && !en0) m_presc = 0;
            m_en = comp_data[0];
            m_ar = comp_data[1];
            m_ie = comp_data[2];
            m_ps = comp_data[15:8];
          end
          8'h04: begin
            m_load = comp_data;
            if (!en0) m_value = comp_data;
          end
          8'h0C: if (comp_data[0] && !fire) m_exp = 0;
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    #2;
    chk("pready", bus.pready, exp_pready);
    chk("irq", irq, m_irq);
    if (bus.pready && bus.psel && bus.penable) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got pready=1 expected 0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_prdata"}, bus.prdata, e.rdata);
        chk({e.name, "_pslverr"}, bus.pslverr, e.err);
      end
    end else begin
      chk("prdata_idle", bus.prdata, 32'h0);
    end
  end

  // ---------------- driver ----------------
  task automatic idle();
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    exp_pready = 0; comp_now = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apb(input bit wr, input logic [31:0] a, input logic [31:0] d, input string name);
    exp_t e;
    @(negedge clk);
    bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    exp_pready = 0; comp_now = 0;
    for (int k = 0; k <= WS; k++) begin
      @(negedge clk);
      bus.penable = 1;
      exp_pready = (k == WS);
      comp_now = (k == WS);
      comp_wr = wr; comp_addr = a; comp_data = d;
      if (k == WS) begin
        e.err   = is_err(wr, a);
        e.rdata = (wr || e.err) ? 32'h0 : model_read(a);
        e.name  = name;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    bit          found;
    logic [31:0] a, d, hi;
    logic [7:0]  off;
    int          r;
    bit          wr;

    idle();
    bus.paddr = 0; bus.pwdata = 0;
    bus0.psel = 0; bus0.penable = 0; bus0.pwrite = 0; bus0.paddr = 0; bus0.pwdata = 0;
    cyc(2);
    rst = 0;

    // Zero-wait instance: ID read in two cycles.
    @(negedge clk);
    bus0.psel = 1; bus0.penable = 0; bus0.paddr = 32'h10;
    #2 chk("ws0_setup_pready", bus0.pready, 1'b0);
    @(negedge clk);
    bus0.penable = 1;
    #2;
    chk("ws0_access_pready", bus0.pready, 1'b1);
    chk("ws0_id_prdata", bus0.prdata, ID);
    chk("ws0_id_pslverr", bus0.pslverr, 1'b0);
    @(negedge clk);
    bus0.psel = 0; bus0.penable = 0;
    #2 chk("ws0_after_pready", bus0.pready, 1'b0);

    // Wait states, LOAD write and readback.
    apb(0, 32'h10, 0, "id_read");
    apb(1, 32'h04, 5, "wr_load5");
    apb(0, 32'h08, 0, "rd_value5");
    apb(0, 32'h04, 0, "rd_load5");

    // One-shot expiry with interrupt.
    apb(1, 32'h04, 3, "os_load");
    apb(1, 32'h00, 32'h0000_0005, "os_ctrl");
    apb(0, 32'h08, 0, "os_value");
    cyc(4);
    apb(0, 32'h0C, 0, "os_status");
    apb(0, 32'h00, 0, "os_ctrl_rd");
    apb(1, 32'h0C, 1, "os_w1c");
    apb(0, 32'h0C, 0, "os_status_clr");

    // Auto-reload with prescale 2.
    apb(1, 32'h04, 2, "ar_load");
    apb(1, 32'h00, 32'h0000_0203, "ar_ctrl");
    for (int i = 0; i < 6; i++) begin
      apb(0, 32'h08, 0, "ar_value");
      cyc(i % 3);
    end
    apb(0, 32'h0C, 0, "ar_status");
    apb(1, 32'h00, 0, "ar_stop");

    // Error responses.
    apb(1, 32'h08, 32'hDEAD_BEEF, "err_wr_value");
    apb(1, 32'h10, 32'h1234_5678, "err_wr_id");
    apb(0, 32'h20, 0, "err_rd_20");
    apb(0, 32'h08, 0, "post_err_value");
    apb(0, 32'h10, 0, "post_err_id");

    // W1C landing on the expiry edge.
    apb(1, 32'h0C, 1, "col_clr");
    apb(1, 32'h04, 10, "col_load");
    apb(1, 32'h00, 32'h0000_0005, "col_ctrl");
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_value == WS + 2) found = 1;
      else @(negedge clk);
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL collision_align: got no alignment expected value %0d", WS + 2);
    end
    apb(1, 32'h0C, 1, "col_w1c");
    apb(0, 32'h0C, 0, "col_status");
    apb(1, 32'h0C, 1, "col_clr2");

    // Reset pulsed on the would-be completion cycle of a LOAD write.
    apb(1, 32'h04, 7, "rst_preload");
    @(negedge clk);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 32'h04; bus.pwdata = 32'h55;
    for (int k = 0; k <= WS; k++) begin
      @(negedge clk);
      bus.penable = 1;
      exp_pready = 0;
      if (k == WS) rst = 1;
    end
    @(negedge clk);
    rst = 0;
    idle();
    apb(0, 32'h04, 0, "load_after_rst");
    apb(0, 32'h00, 0, "ctrl_after_rst");

    // Randomised traffic.
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 11);
      hi = $urandom();
      if (r < 10) off = 8'(4 * (r % 5)) | 8'($urandom_range(0, 3));
      else off = 8'($urandom_range(0, 255));
      a  = {hi[31:8], off};
      wr = 1'($urandom_range(0, 1));
      case (off & 8'hFC)
        8'h00:   d = $urandom() & 32'hFFFF_03FF;
        8'h04:   d = 32'($urandom_range(0, 12));
        default: d = $urandom();
      endcase
      apb(wr, a, d, wr ? "rnd_wr" : "rnd_rd");
      cyc($urandom_range(0, 3));
    end

    cyc(5);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
